// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- data-memory access controller between EX and MEM.
//
// Accepts one load/store per instruction from EX, runs a single req/ack bus
// transaction, stalls the pipeline until the bus answers, and presents the
// aligned, extended load data as a one-cycle result to MEM.
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   defined   : a watchdog aborts a REQ that sees no ack for TIMEOUT_CYC
//               cycles and completes the op with bus_err=1.
//   undefined : REQ waits indefinitely, bus_err stays 0, no counter exists.
//
// Parameters
//   ADDR_W      byte-address width on the EX side and the bus side
//   TIMEOUT_CYC REQ cycles without ack before abort (watchdog build only)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   ex_valid/we/size/signed/addr/wdata
//                       memory op presented by EX
//   stall               freeze PC and IF/ID/EX registers
//   mem_valid           one-cycle completion pulse
//   mem_out             load result (0 for stores and errors)
//   misalign, bus_err   qualifiers of mem_valid
//   dbus_req/we/addr/be/wdata
//                       bus request side (registered, stable during REQ)
//   dbus_rdata, dbus_ack
//                       bus response side
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [1:0]        ex_size,
    input  logic              ex_signed,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              stall,
    output logic              mem_valid,
    output logic [31:0]       mem_out,
    output logic              misalign,
    output logic              bus_err,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e state_q, state_d;

    // Latched op (held stable for the whole REQ phase)
    logic              we_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [1:0]        lo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;

    // Completion outputs, loaded on the transition into DONE
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_out_q, mem_out_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic stall_s;
    logic misal_s;
    logic accept_s;
    logic timeout_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lo[0];
            2'b10:   is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    // Only called for aligned ops, so the shifted pattern never leaves 4 bits.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = 4'b0011 << lo;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    // Move the addressed lane down to bit 0, then extend; words pass untouched.
    function automatic logic [31:0] load_format(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] lo, input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {lo, 3'b000};
        case (size)
            2'b00:   load_format = {{24{sgn & lane[7]}}, lane[7:0]};
            2'b01:   load_format = {{16{sgn & lane[15]}}, lane[15:0]};
            default: load_format = rdata;
        endcase
    endfunction

    assign misal_s  = is_misaligned(ex_size, ex_addr[1:0]);
    assign accept_s = (state_q == IDLE) && ex_valid;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Watchdog counter: zero outside REQ, counts REQ cycles that saw no ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if ((state_q == REQ) && !dbus_ack) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= {CNT_W{1'b0}};
        end
    end

    // The final no-ack REQ cycle is the one where the count would reach the limit.
    assign timeout_s = (state_q == REQ) && !dbus_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ack takes priority over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    state_d = misal_s ? DONE : REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dbus_ack || timeout_s) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: stall plus next values of the completion registers
    always_comb begin
        stall_s     = 1'b0;
        mem_valid_d = 1'b0;
        mem_out_d   = 32'h0000_0000;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                stall_s     = ex_valid;
                mem_valid_d = ex_valid & misal_s;
                misalign_d  = ex_valid & misal_s;
            end
            REQ: begin
                stall_s = 1'b1;
                if (dbus_ack) begin
                    mem_valid_d = 1'b1;
                    mem_out_d   = we_q ? 32'h0000_0000
                                       : load_format(size_q, sgn_q, lo_q, dbus_rdata);
                end else if (timeout_s) begin
                    mem_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                end else begin
                    mem_valid_d = 1'b0;
                end
            end
            // DONE ignores ex_valid: EX still shows the completed op.
            DONE:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Op latch: captured once on acceptance of an aligned op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            lo_q    <= 2'b00;
            addr_q  <= {ADDR_W{1'b0}};
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
        end else if (accept_s && !misal_s) begin
            we_q    <= ex_we;
            size_q  <= ex_size;
            sgn_q   <= ex_signed;
            lo_q    <= ex_addr[1:0];
            addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
            be_q    <= byte_en(ex_size, ex_addr[1:0]);
            wdata_q <= store_data(ex_size, ex_wdata);
        end
    end

    // Completion registers: non-zero only during the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_out_q   <= 32'h0000_0000;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_out_q   <= mem_out_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall      = stall_s;
    assign mem_valid  = mem_valid_q;
    assign mem_out    = mem_out_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;
    assign dbus_req   = (state_q == REQ);
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl -- directed, table-driven bench for dmem_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic        mem_valid;
    logic [31:0] mem_out;
    logic        misalign;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    int checks;
    int errors;

    dmem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_size    (ex_size),
        .ex_signed  (ex_signed),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .stall      (stall),
        .mem_valid  (mem_valid),
        .mem_out    (mem_out),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_be    (dbus_be),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        ex_valid  = 1'b1;
        ex_we     = v.we;
        ex_size   = v.size;
        ex_signed = v.sgn;
        ex_addr   = v.addr;
        ex_wdata  = v.wdata;
    endtask

    // One op from acceptance through the bubble cycle after DONE.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive_op(v);
        dbus_ack = 1'b0;
        #1;
        chk({tag, ".accept_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, ".accept_req"}, {31'd0, dbus_req}, 32'd0);
        if (v.exp_mis) begin
            @(negedge clk);
            #1;
            chk({tag, ".mis_valid"}, {31'd0, mem_valid}, 32'd1);
            chk({tag, ".mis_flag"}, {31'd0, misalign}, 32'd1);
            chk({tag, ".mis_out"}, mem_out, 32'd0);
            chk({tag, ".mis_req"}, {31'd0, dbus_req}, 32'd0);
            chk({tag, ".mis_stall"}, {31'd0, stall}, 32'd0);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                @(negedge clk);
                if (w == v.waits) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = v.rdata;
                end else begin
                    dbus_ack   = 1'b0;
                    dbus_rdata = 32'hA5A5_5A5A;
                end
                #1;
                chk({tag, ".req"}, {31'd0, dbus_req}, 32'd1);
                chk({tag, ".req_stall"}, {31'd0, stall}, 32'd1);
                chk({tag, ".req_valid"}, {31'd0, mem_valid}, 32'd0);
                chk({tag, ".we"}, {31'd0, dbus_we}, {31'd0, v.we});
                chk({tag, ".addr"}, dbus_addr, v.exp_addr);
                chk({tag, ".be"}, {28'd0, dbus_be}, {28'd0, v.exp_be});
                chk({tag, ".wdata"}, dbus_wdata, v.exp_wdata);
            end
            @(negedge clk);
            dbus_ack   = 1'b0;
            dbus_rdata = 32'h0000_0000;
            #1;
            chk({tag, ".done_valid"}, {31'd0, mem_valid}, 32'd1);
            chk({tag, ".done_out"}, mem_out, v.exp_out);
            chk({tag, ".done_mis"}, {31'd0, misalign}, 32'd0);
            chk({tag, ".done_err"}, {31'd0, bus_err}, 32'd0);
            chk({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
            chk({tag, ".done_req"}, {31'd0, dbus_req}, 32'd0);
        end
        // Bubble: the op still shown in DONE must not have been reissued.
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk({tag, ".bubble_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, ".bubble_req"}, {31'd0, dbus_req}, 32'd0);
        chk({tag, ".bubble_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        //          we    size   sgn   addr          wdata         rdata         w  mis   exp_addr      be       exp_wdata     exp_out
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0000_0000, 32'h8011_2233, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0000, 32'h8011_2233, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 32'h0000_0080};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 3, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0000_0000, 32'h8001_7FFF, 1, 1'b0, 32'h0000_0000, 4'b1100, 32'h0000_0000, 32'hFFFF_8001};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8001_F00D, 0, 1'b0, 32'h0000_0000, 4'b0011, 32'h0000_0000, 32'h0000_F00D};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 2, 1'b0, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 0, 1'b0, 32'h0000_03FC, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0105, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'h1111_1111, 32'h0000_0000, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'h0000_7F00, 0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_0000, 32'h0000_007F};
        vecs[12] = '{1'b0, 2'b10, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h8000_0000, 1, 1'b0, 32'h0000_0004, 4'b1111, 32'h0000_0000, 32'h8000_0000};

        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        ex_we      = 1'b0;
        ex_size    = 2'b00;
        ex_signed  = 1'b0;
        ex_addr    = 32'h0000_0000;
        ex_wdata   = 32'h0000_0000;
        dbus_rdata = 32'h0000_0000;
        dbus_ack   = 1'b0;

        // Reset state
        #12;
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.valid", {31'd0, mem_valid}, 32'd0);
        chk("rst.out", mem_out, 32'd0);
        chk("rst.mis", {31'd0, misalign}, 32'd0);
        chk("rst.err", {31'd0, bus_err}, 32'd0);
        chk("rst.req", {31'd0, dbus_req}, 32'd0);
        chk("rst.we", {31'd0, dbus_we}, 32'd0);
        chk("rst.addr", dbus_addr, 32'd0);
        chk("rst.be", {28'd0, dbus_be}, 32'd0);
        chk("rst.wdata", dbus_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the second REQ cycle; a later ack must be ignored.
        v = vecs[0];
        v.addr = 32'h0000_0040;
        @(negedge clk);
        drive_op(v);
        #1;
        chk("rstmid.accept_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("rstmid.req1", {31'd0, dbus_req}, 32'd1);
        @(negedge clk);
        #1;
        chk("rstmid.req2", {31'd0, dbus_req}, 32'd1);
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        #1;
        chk("rstmid.req_drop", {31'd0, dbus_req}, 32'd0);
        chk("rstmid.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid.valid0", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h1357_9BDF;
        #1;
        chk("rstmid.late_req", {31'd0, dbus_req}, 32'd0);
        @(negedge clk);
        dbus_ack = 1'b0;
        #1;
        chk("rstmid.valid1", {31'd0, mem_valid}, 32'd0);
        chk("rstmid.idle_req", {31'd0, dbus_req}, 32'd0);
        chk("rstmid.out", mem_out, 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // No ack: four REQ cycles, then DONE with bus_err.
        v = vecs[0];
        v.addr = 32'h0000_0080;
        @(negedge clk);
        drive_op(v);
        #1;
        chk("to.accept_stall", {31'd0, stall}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("to.req", {31'd0, dbus_req}, 32'd1);
            chk("to.req_valid", {31'd0, mem_valid}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("to.done_valid", {31'd0, mem_valid}, 32'd1);
        chk("to.done_err", {31'd0, bus_err}, 32'd1);
        chk("to.done_out", mem_out, 32'd0);
        chk("to.done_req", {31'd0, dbus_req}, 32'd0);
        chk("to.done_mis", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("to.bubble_valid", {31'd0, mem_valid}, 32'd0);
        chk("to.bubble_err", {31'd0, bus_err}, 32'd0);
        // Ack on the 4th REQ cycle wins over the watchdog.
        v = vecs[0];
        v.waits = 3;
        v.rdata = 32'h0BAD_F00D;
        v.exp_out = 32'h0BAD_F00D;
        run_vec(v, "to_ack4");
`else
        // Without the watchdog a long wait still completes normally.
        v = vecs[0];
        v.addr = 32'h0000_0010;
        v.exp_addr = 32'h0000_0010;
        v.waits = 20;
        v.rdata = 32'h0BAD_F00D;
        v.exp_out = 32'h0BAD_F00D;
        run_vec(v, "longwait");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
